// File: rtl/vram_pkg.sv
// Shared types and default geometry for the video RAM path.
// Also used by the VGA controller so both sides agree on AW/DW.
package vram_pkg;

  localparam int VRAM_AW = 16;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_VGA  = 2'd1,
    ARB_CPU  = 2'd2
  } owner_e;

  typedef struct packed {
    logic valid;
    logic is_cpu;
  } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Read-return tag delay line, DEPTH stages with latency DEPTH cycles from tag_in to tag_out.
// No backpressure: one tag enters and one leaves every cycle.
module vram_rd_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock_50,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [DEPTH];

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter, VGA priority; grant->mem strobe 1 cycle, grant->rvalid RD_LAT+1 cycles.
// Requesters hold req until gnt; VRAM_ARB_STARVE_GUARD_EN forces a CPU grant after MAX_WAIT lost cycles.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW       = VRAM_AW,
  parameter int DW       = VRAM_DW,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock_50,
  input  logic          reset_n,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 3 || MAX_WAIT < 1) begin : g_param_check
    $error("vram_arbiter: RD_LAT must be 1..3 and MAX_WAIT >= 1");
  end

  owner_e  owner_q, owner_d;
  logic    run_q;
  logic    force_cpu;
  rd_tag_t tag_in, tag_out;

  // Grants stay low until the first clock edge after reset release.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      wait_q <= '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`endif

  always_comb begin
    force_cpu = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    force_cpu = cpu_req && (wait_q == WAIT_W'(MAX_WAIT));
`endif
    vga_gnt = run_q && vga_req && !force_cpu;
    cpu_gnt = run_q && cpu_req && (!vga_req || force_cpu);
    owner_d = ARB_IDLE;
    if (vga_gnt)      owner_d = ARB_VGA;
    else if (cpu_gnt) owner_d = ARB_CPU;
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) owner_q <= ARB_IDLE;
    else          owner_q <= owner_d;
  end

  // Address/data hold their last value on idle cycles; only the strobes drop.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (owner_d)
        ARB_VGA: begin
          mem_we   <= 1'b0;
          mem_addr <= vga_addr;
        end
        ARB_CPU: begin
          mem_we    <= cpu_we;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  assign mem_en = (owner_q != ARB_IDLE);

  assign tag_in.valid  = vga_gnt || (cpu_gnt && !cpu_we);
  assign tag_in.is_cpu = cpu_gnt;

  vram_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .tag_in   (tag_in),
    .tag_out  (tag_out)
  );

  assign vga_rvalid = tag_out.valid && !tag_out.is_cpu;
  assign cpu_rvalid = tag_out.valid &&  tag_out.is_cpu;
  assign vga_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency RAM model.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic          vga_req  = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_gnt;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          cpu_req  = 1'b0;
  logic          cpu_we   = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat  = '0;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #10 clock_50 = ~clock_50;

  always @(posedge clock_50) begin
    if (pl_en) ram[pl_addr] <= pl_dat;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(4)) dut (
    .clock_50   (clock_50),
    .reset_n    (reset_n),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rdata  (vga_rdata),
    .vga_rvalid (vga_rvalid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic test_reset();
    reset_n = 1'b0; vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vga_addr = 16'h0001; cpu_addr = 16'h0002;
    repeat (3) @(negedge clock_50);
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt, vga_rvalid, cpu_rvalid, mem_en, mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 000000", {vga_gnt, cpu_gnt, vga_rvalid, cpu_rvalid, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_bus: got %h want 000000", {mem_addr, mem_wdata});
    end
    @(negedge clock_50);
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL gnt_before_edge: got %b want 00", {vga_gnt, cpu_gnt});
    end
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL gnt_after_edge: got %b want 10", {vga_gnt, cpu_gnt});
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    repeat (4) @(negedge clock_50);
  endtask

  task automatic test_vga_read();
    pl_en = 1'b1; pl_addr = 16'h0010; pl_dat = 8'hA5;
    @(negedge clock_50);
    pl_en = 1'b0;
    vga_req = 1'b1; vga_addr = 16'h0010;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL vga_gnt: got %b want 10", {vga_gnt, cpu_gnt});
    end
    @(negedge clock_50);
    vga_req = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      n_err++;
      $display("FAIL vga_strobe: got en=%b we=%b addr=%h want en=1 we=0 addr=0010", mem_en, mem_we, mem_addr);
    end
    n_cmp++;
    if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL vga_rvalid_early: got %b want 00", {vga_rvalid, cpu_rvalid});
    end
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({vga_rvalid, cpu_rvalid, mem_en} !== 3'b100) begin
      n_err++;
      $display("FAIL vga_rvalid: got %b want 100", {vga_rvalid, cpu_rvalid, mem_en});
    end
    n_cmp++;
    if (vga_rdata !== 8'hA5) begin
      n_err++;
      $display("FAIL vga_rdata: got %h want a5", vga_rdata);
    end
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL vga_rvalid_single: got %b want 00", {vga_rvalid, cpu_rvalid});
    end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clock_50);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL cpu_wr_gnt: got %b want 01", {vga_gnt, cpu_gnt});
    end
    @(negedge clock_50);
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0200, 8'h3C}) begin
      n_err++;
      $display("FAIL cpu_wr_strobe: got en=%b we=%b addr=%h wd=%h want 1 1 0200 3c", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL cpu_rd_gnt: got %b want 01", {vga_gnt, cpu_gnt});
    end
    @(negedge clock_50);
    cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0200}) begin
      n_err++;
      $display("FAIL cpu_rd_strobe: got en=%b we=%b addr=%h want 1 0 0200", mem_en, mem_we, mem_addr);
    end
    n_cmp++;
    if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL cpu_wr_no_rvalid: got %b want 00", {vga_rvalid, cpu_rvalid});
    end
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({cpu_rvalid, vga_rvalid, mem_en} !== 3'b100) begin
      n_err++;
      $display("FAIL cpu_rvalid: got %b want 100", {cpu_rvalid, vga_rvalid, mem_en});
    end
    n_cmp++;
    if (cpu_rdata !== 8'h3C) begin
      n_err++;
      $display("FAIL cpu_rdata: got %h want 3c", cpu_rdata);
    end
    @(negedge clock_50);
    #1;
    n_cmp++;
    if ({vga_rvalid, cpu_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL cpu_rvalid_single: got %b want 00", {vga_rvalid, cpu_rvalid});
    end
  endtask

  task automatic test_contention();
    logic [1:0] hist [100];
    logic [1:0] exp_g;
    logic [1:0] exp_rv;
    @(negedge clock_50);
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vga_addr = 16'h0010; cpu_addr = 16'h0200;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clock_50);
      #1;
      exp_g   = (GUARD && (i % 5 == 4)) ? 2'b01 : 2'b10;
      hist[i] = exp_g;
      exp_rv  = (i < 2) ? 2'b00 : hist[i-2];
      n_cmp++;
      if ({vga_gnt, cpu_gnt} !== exp_g) begin
        n_err++;
        $display("FAIL contend_gnt[%0d]: got %b want %b", i, {vga_gnt, cpu_gnt}, exp_g);
      end
      n_cmp++;
      if ({vga_rvalid, cpu_rvalid} !== exp_rv) begin
        n_err++;
        $display("FAIL contend_rvalid[%0d]: got %b want %b", i, {vga_rvalid, cpu_rvalid}, exp_rv);
      end
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    repeat (4) @(negedge clock_50);
  endtask

  task automatic test_reset_mid();
    @(negedge clock_50);
    vga_req = 1'b1; vga_addr = 16'h0010;
    #1;
    n_cmp++;
    if ({vga_gnt, cpu_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_gnt: got %b want 10", {vga_gnt, cpu_gnt});
    end
    @(negedge clock_50);
    vga_req = 1'b0; reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_en, mem_we, vga_rvalid, cpu_rvalid} !== 4'b0) begin
      n_err++;
      $display("FAIL mid_in_reset: got %b want 0000", {mem_en, mem_we, vga_rvalid, cpu_rvalid});
    end
    repeat (2) @(negedge clock_50);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_50);
      #1;
      n_cmp++;
      if ({vga_rvalid, cpu_rvalid, mem_en} !== 3'b000) begin
        n_err++;
        $display("FAIL mid_after_reset[%0d]: got %b want 000", i, {vga_rvalid, cpu_rvalid, mem_en});
      end
    end
  endtask

  initial begin
    test_reset();
    test_vga_read();
    test_cpu_write_read();
    test_contention();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
